// File: rtl/cmos_capture_data.sv
// Capture writer for the camera side of the RGB565 frame buffer.
// Pairs DVP bytes into RGB565 pixels and crops each frame to H_ACT x V_ACT.
// Write requests are issued once the sensor has settled for WAIT_FRAME
// vsync pulses after reset.
module cmos_capture_data #(
  parameter int WAIT_FRAME = 10,
  parameter int H_ACT      = 1024,
  parameter int V_ACT      = 768
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cmos_wr_en,
  output logic [15:0] cmos_wr_data,
  output logic        cmos_frame_start,
  output logic        cmos_capturing,
  output logic        line_err
);

  // The limits are 12 bits wide so that a window of 2048 still compares
  // correctly against the 11-bit counters.
  localparam logic [11:0] H_LIM  = 12'(H_ACT);
  localparam logic [11:0] V_LIM  = 12'(V_ACT);
  localparam logic [7:0]  WAIT_N = 8'(WAIT_FRAME);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  typedef enum logic {SKIP, CAPTURE} state_t;

  state_t      state_reg;
  logic        vsync_d0, vsync_d1;
  logic        href_d0, href_d1;
  logic [7:0]  data_d0;
  logic [7:0]  frame_cnt;
  logic        byte_flag;
  logic [7:0]  hi_byte;
  logic [10:0] x_cnt, y_cnt;
  logic        wr_req_reg;
  logic [15:0] pix_reg;

  logic vs_rise, vs_fall, href_fall, pixel_done, in_window;

  assign vs_rise    = vsync_d0 & ~vsync_d1;
  assign vs_fall    = ~vsync_d0 & vsync_d1;
  assign href_fall  = ~href_d0 & href_d1;
  // A pixel that completes on the same cycle as a vsync rise is discarded.
  assign pixel_done = href_d0 & byte_flag & ~vs_rise;
  assign in_window  = ({1'b0, x_cnt} < H_LIM) && ({1'b0, y_cnt} < V_LIM);

  // Register the sensor inputs once; vsync and href get a second stage for edge detection.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      vsync_d0 <= 1'b0;
      vsync_d1 <= 1'b0;
      href_d0  <= 1'b0;
      href_d1  <= 1'b0;
      data_d0  <= 8'd0;
    end else begin
      vsync_d0 <= cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= cam_href;
      href_d1  <= href_d0;
      data_d0  <= cam_data;
    end
  end

  // Skip the settling frames, then stay in capture until reset.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_reg      <= SKIP;
      frame_cnt      <= 8'd0;
      cmos_capturing <= 1'b0;
    end else begin
      case (state_reg)
        SKIP: begin
          if (vs_rise) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (frame_cnt + 8'd1 == WAIT_N) begin
              state_reg      <= CAPTURE;
              cmos_capturing <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          state_reg      <= CAPTURE;
          cmos_capturing <= 1'b1;
        end
        default: begin
          state_reg      <= SKIP;
          cmos_capturing <= 1'b0;
        end
      endcase
    end
  end

  // Pair bytes and track the pixel/line position within the frame.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      byte_flag <= 1'b0;
      hi_byte   <= 8'd0;
      x_cnt     <= 11'd0;
      y_cnt     <= 11'd0;
    end else if (vs_rise) begin
      byte_flag <= 1'b0;
      x_cnt     <= 11'd0;
      y_cnt     <= 11'd0;
    end else if (href_d0) begin
      byte_flag <= ~byte_flag;
      if (!byte_flag) begin
        hi_byte <= data_d0;
      end else if (x_cnt != CNT_MAX) begin
        x_cnt <= x_cnt + 11'd1;
      end
    end else begin
      byte_flag <= 1'b0;
      x_cnt     <= 11'd0;
      if (href_d1 && (y_cnt != CNT_MAX)) begin
        y_cnt <= y_cnt + 11'd1;
      end
    end
  end

  // Two-stage write path: qualify the pixel, then present it to the buffer.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      wr_req_reg       <= 1'b0;
      pix_reg          <= 16'd0;
      cmos_wr_en       <= 1'b0;
      cmos_wr_data     <= 16'd0;
      cmos_frame_start <= 1'b0;
    end else begin
      wr_req_reg       <= pixel_done && (state_reg == CAPTURE) && in_window;
      pix_reg          <= {hi_byte, data_d0};
      cmos_wr_en       <= wr_req_reg;
      if (wr_req_reg) begin
        cmos_wr_data <= pix_reg;
      end
      cmos_frame_start <= vs_fall && (state_reg == CAPTURE);
    end
  end

  // Sticky flag for a line that ended with half a pixel pending.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      line_err <= 1'b0;
    end else if (href_fall && byte_flag) begin
      line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_capture_data.sv
// Self-checking bench for cmos_capture_data with a small capture window.
// The reference model counts bytes per line and lines per frame and queues
// the pixels that should reach the buffer.
module tb_cmos_capture_data;

  localparam int WAIT_FRAME = 2;
  localparam int H_ACT      = 4;
  localparam int V_ACT      = 2;

  logic        pixel_clk = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cam_href  = 1'b0;
  logic [7:0]  cam_data  = 8'd0;
  logic        cmos_wr_en;
  logic [15:0] cmos_wr_data;
  logic        cmos_frame_start;
  logic        cmos_capturing;
  logic        line_err;

  cmos_capture_data #(
    .WAIT_FRAME(WAIT_FRAME),
    .H_ACT(H_ACT),
    .V_ACT(V_ACT)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst(sys_rst),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
    .cmos_wr_en(cmos_wr_en),
    .cmos_wr_data(cmos_wr_data),
    .cmos_frame_start(cmos_frame_start),
    .cmos_capturing(cmos_capturing),
    .line_err(line_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_rises, m_bytes, m_line, exp_fs;
  bit          m_capt, exp_line_err;
  logic        m_prev_vs, m_prev_hr;
  logic [7:0]  m_hi;
  logic [15:0] exp_q[$];

  // Observed writes and frame-start pulses
  logic [15:0] act_q[$];
  int          act_fs = 0;
  logic        prev_wr = 1'b0;

  // Collect DUT writes; two consecutive write cycles are never legal.
  always @(negedge pixel_clk) begin
    if (cmos_wr_en) begin
      act_q.push_back(cmos_wr_data);
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL back_to_back: wr_en high two cycles in a row at %0t", $time);
      end
    end
    if (cmos_frame_start) act_fs++;
    prev_wr <= cmos_wr_en;
  end

  task automatic model_reset();
    m_rises = 0; m_bytes = 0; m_line = 0; exp_fs = 0;
    m_capt = 0; exp_line_err = 0;
    m_prev_vs = 0; m_prev_hr = 0; m_hi = 8'd0;
    exp_q.delete();
  endtask

  // Drive one input cycle and advance the reference model by the same cycle.
  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge pixel_clk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    if (!vs && m_prev_vs && m_capt) exp_fs++;
    if (vs && !m_prev_vs) begin
      m_rises++;
      if (m_rises >= WAIT_FRAME) m_capt = 1;
      m_bytes = 0;
      m_line  = 0;
    end else if (hr) begin
      m_bytes++;
      if (m_bytes % 2 == 1) m_hi = d;
      else if (m_capt && (m_bytes / 2 - 1) < H_ACT && m_line < V_ACT)
        exp_q.push_back({m_hi, d});
    end else begin
      if (m_prev_hr) begin
        if (m_bytes % 2 == 1) exp_line_err = 1;
        m_line++;
      end
      m_bytes = 0;
    end
    m_prev_vs = vs;
    m_prev_hr = hr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, 8'($urandom));
    idle(3);
  endtask

  task automatic send_lines(input int nlines, input int nbytes);
    for (int i = 0; i < nlines; i++) send_line(nbytes);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0);
    idle(4);
  endtask

  task automatic test_reset();
    model_reset();
    sys_rst = 1'b1;
    repeat (4) @(negedge pixel_clk);
    checks += 5;
    if (cmos_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", cmos_wr_en); end
    if (cmos_wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0000", cmos_wr_data); end
    if (cmos_frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", cmos_frame_start); end
    if (cmos_capturing !== 1'b0) begin errors++; $display("FAIL reset_capturing: got %b want 0", cmos_capturing); end
    if (line_err !== 1'b0) begin errors++; $display("FAIL reset_line_err: got %b want 0", line_err); end
    sys_rst = 1'b0;
    act_q.delete(); act_fs = 0;
    $display("test_reset done");
  endtask

  task automatic test_skip();
    for (int f = 1; f <= 4; f++) begin
      send_lines(2, 8);
      if (f == 2) begin
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0);
        checks++;
        if (cmos_capturing !== 1'b0) begin errors++; $display("FAIL capture_early: got %b want 0", cmos_capturing); end
        drive(1'b1, 1'b0, 8'd0);
        checks++;
        if (cmos_capturing !== 1'b1) begin errors++; $display("FAIL capture_rise: got %b want 1", cmos_capturing); end
        idle(4);
      end else begin
        vsync_pulse();
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
        errors++; $display("FAIL skip_writes_f%0d: got %0d writes want %0d", f, act_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL skip_data_f%0d[%0d]: got %h want %h", f, i, act_q[i], exp_q[i]); end
      end
      checks++;
      if (cmos_capturing !== m_capt) begin errors++; $display("FAIL skip_capturing_f%0d: got %b want %b", f, cmos_capturing, m_capt); end
      $display("test_skip frame %0d: writes=%0d expected=%0d", f, act_q.size(), exp_q.size());
      act_q.delete(); exp_q.delete();
    end
    checks++;
    if (act_fs != exp_fs) begin errors++; $display("FAIL skip_frame_start: got %0d want %0d", act_fs, exp_fs); end
    act_fs = 0; exp_fs = 0;
  endtask

  task automatic test_latency();
    int seen = -1;
    logic [15:0] seen_data = 16'd0;
    drive(1'b0, 1'b1, 8'hF8);
    drive(1'b0, 1'b1, 8'h1F);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, 8'd0);
      if (cmos_wr_en && seen < 0) begin seen = k; seen_data = cmos_wr_data; end
    end
    checks += 2;
    if (seen != 3) begin errors++; $display("FAIL latency: got %0d cycles want 3", seen); end
    if (seen_data !== 16'hF81F) begin errors++; $display("FAIL latency_data: got %h want f81f", seen_data); end
    vsync_pulse();
    checks++;
    if (act_q.size() != 1 || exp_q.size() != 1 || act_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL latency_queue: got %0d writes want %0d", act_q.size(), exp_q.size());
    end
    $display("test_latency: latency=%0d data=%h", seen, seen_data);
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_window();
    send_lines(3, 12);
    vsync_pulse();
    checks++;
    if (act_q.size() != 8 || exp_q.size() != 8) begin
      errors++; $display("FAIL window_count: got %0d writes want 8 (model %0d)", act_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL window_data[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    $display("test_window: writes=%0d", act_q.size());
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_vsync_midline();
    act_fs = 0; exp_fs = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom));
    drive(1'b1, 1'b1, 8'($urandom));
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    idle(4);
    send_lines(2, 8);
    vsync_pulse();
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midline_count: got %0d writes want %0d", act_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL midline_data[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    checks += 2;
    if (act_fs != 2) begin errors++; $display("FAIL midline_frame_start: got %0d pulses want 2", act_fs); end
    if (line_err !== 1'b0) begin errors++; $display("FAIL midline_line_err: got %b want 0", line_err); end
    $display("test_vsync_midline: writes=%0d frame_starts=%0d", act_q.size(), act_fs);
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_odd_line();
    send_line(7);
    checks++;
    if (line_err !== 1'b1) begin errors++; $display("FAIL odd_line_err: got %b want 1", line_err); end
    send_line(8);
    vsync_pulse();
    send_lines(2, 8);
    vsync_pulse();
    checks++;
    if (act_q.size() != exp_q.size() || exp_q.size() != 15) begin
      errors++; $display("FAIL odd_count: got %0d writes want 15 (model %0d)", act_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_data[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    checks++;
    if (line_err !== 1'b1) begin errors++; $display("FAIL odd_line_err_sticky: got %b want 1", line_err); end
    $display("test_odd_line: writes=%0d line_err=%b", act_q.size(), line_err);
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    act_fs = 0; exp_fs = 0;
    for (int f = 0; f < 5; f++) begin
      int nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) send_line($urandom_range(0, 14));
      vsync_pulse();
      checks++;
      if (act_q.size() != exp_q.size()) begin
        errors++; $display("FAIL random_count_f%0d: got %0d writes want %0d", f, act_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data_f%0d[%0d]: got %h want %h", f, i, act_q[i], exp_q[i]); end
      end
      $display("test_random frame %0d: lines=%0d writes=%0d", f, nl, act_q.size());
      act_q.delete(); exp_q.delete();
    end
    checks += 2;
    if (act_fs != exp_fs) begin errors++; $display("FAIL random_frame_start: got %0d want %0d", act_fs, exp_fs); end
    if (line_err !== exp_line_err) begin errors++; $display("FAIL random_line_err: got %b want %b", line_err, exp_line_err); end
  endtask

  task automatic test_reset_midframe();
    send_line(8);
    @(negedge pixel_clk);
    sys_rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
    model_reset();
    @(negedge pixel_clk);
    checks += 5;
    if (cmos_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en: got %b want 0", cmos_wr_en); end
    if (cmos_wr_data !== 16'd0) begin errors++; $display("FAIL midrst_wr_data: got %h want 0000", cmos_wr_data); end
    if (cmos_frame_start !== 1'b0) begin errors++; $display("FAIL midrst_frame_start: got %b want 0", cmos_frame_start); end
    if (cmos_capturing !== 1'b0) begin errors++; $display("FAIL midrst_capturing: got %b want 0", cmos_capturing); end
    if (line_err !== 1'b0) begin errors++; $display("FAIL midrst_line_err: got %b want 0", line_err); end
    sys_rst = 1'b0;
    act_q.delete(); act_fs = 0;
    for (int f = 1; f <= 3; f++) begin
      send_lines(2, 8);
      vsync_pulse();
      checks++;
      if (cmos_capturing !== (f >= 2)) begin errors++; $display("FAIL midrst_capturing_f%0d: got %b want %b", f, cmos_capturing, (f >= 2)); end
    end
    checks++;
    if (act_q.size() != exp_q.size() || exp_q.size() != 8) begin
      errors++; $display("FAIL midrst_count: got %0d writes want 8 (model %0d)", act_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_data[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    checks++;
    if (act_fs != exp_fs) begin errors++; $display("FAIL midrst_frame_start: got %0d want %0d", act_fs, exp_fs); end
    $display("test_reset_midframe: writes=%0d frame_starts=%0d", act_q.size(), act_fs);
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_skip();
    test_latency();
    test_window();
    test_vsync_midline();
    test_odd_line();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
